// File: rtl/pll_loop_pkg.sv
// Shared types and helpers for the PLL loop filter and the ADC capture stage.
package pll_loop_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PROP,
        INTEG,
        SUM,
        OUT
    } loop_state_t;

    // Mid-scale DAC code for a given code width.
    function automatic logic [63:0] dac_mid(input int width);
        return 64'd1 << (width - 1);
    endfunction

    // Signed add clamped to the range of a width-bit signed value (width <= 62).
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 width
    );
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/pll_sat_clamp.sv
// Combinational clamp of a wide signed sum onto an unsigned OUT_WIDTH-bit code.
module pll_sat_clamp
    import pll_loop_pkg::*;
#(
    parameter int IN_WIDTH  = 34,
    parameter int OUT_WIDTH = 16
) (
    input  logic signed [IN_WIDTH-1:0] sum_i,
    output logic [OUT_WIDTH-1:0]       code_o
);

    localparam logic signed [IN_WIDTH-1:0] CODE_MAX =
        {{(IN_WIDTH - OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

    always_comb begin
        code_o = sum_i[OUT_WIDTH-1:0];
        if (sum_i[IN_WIDTH-1]) begin
            code_o = '0;
        end else if (sum_i > CODE_MAX) begin
            code_o = '1;
        end
    end

endmodule

// File: rtl/pll_loop_filter.sv
// PI loop filter producing the DAC8411 code from ADC phase-error samples.
// Optional slew limiter on the output code: PLL_LOOP_FILTER_SLEW_LIMIT_EN.
module pll_loop_filter
    import pll_loop_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int KP_SHIFT   = 4,
    parameter int KI_SHIFT   = 10,
    parameter int MAX_STEP   = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] err_data,
    input  logic                         err_valid,
    input  logic                         overrun_clr,
    output logic [DATA_WIDTH-1:0]        dac_code,
    output logic                         dac_update,
    output logic                         busy,
    output logic                         overrun
);

    localparam int SUM_W = ACC_WIDTH + 2;
    localparam logic [DATA_WIDTH-1:0] DAC_MID = DATA_WIDTH'(dac_mid(DATA_WIDTH));

    loop_state_t                  state_q, state_d;
    logic signed [DATA_WIDTH-1:0] err_q, err_d;
    logic signed [DATA_WIDTH-1:0] p_q, p_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0]  i_q, i_d;
    logic [DATA_WIDTH-1:0]        sum_q, sum_d;
    logic [DATA_WIDTH-1:0]        dac_code_q, dac_code_d;
    logic                         dac_update_q, dac_update_d;
    logic                         overrun_q, overrun_d;

    logic signed [SUM_W-1:0]      sum_wide;
    logic [DATA_WIDTH-1:0]        clamped;
    logic [DATA_WIDTH-1:0]        new_code;

    // Mid-scale is unsigned; p and i are sign-extended before the add.
    assign sum_wide = {{(SUM_W - DATA_WIDTH){1'b0}}, DAC_MID}
                    + {{(SUM_W - DATA_WIDTH){p_q[DATA_WIDTH-1]}}, p_q}
                    + {{2{i_q[ACC_WIDTH-1]}}, i_q};

    pll_sat_clamp #(
        .IN_WIDTH  (SUM_W),
        .OUT_WIDTH (DATA_WIDTH)
    ) u_clamp (
        .sum_i  (sum_wide),
        .code_o (clamped)
    );

`ifdef PLL_LOOP_FILTER_SLEW_LIMIT_EN
    localparam logic signed [DATA_WIDTH+1:0] STEP_POS = (DATA_WIDTH + 2)'(MAX_STEP);
    logic signed [DATA_WIDTH+1:0] delta;
    logic signed [DATA_WIDTH+1:0] delta_lim;

    always_comb begin
        delta     = $signed({2'b00, sum_q}) - $signed({2'b00, dac_code_q});
        delta_lim = delta;
        if (delta > STEP_POS) begin
            delta_lim = STEP_POS;
        end else if (delta < -STEP_POS) begin
            delta_lim = -STEP_POS;
        end
        new_code = DATA_WIDTH'(dac_code_q + delta_lim);
    end
`else
    logic [31:0] unused_max_step;
    assign unused_max_step = MAX_STEP;
    assign new_code        = sum_q;
`endif

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        p_d          = p_q;
        acc_d        = acc_q;
        i_d          = i_q;
        sum_d        = sum_q;
        dac_code_d   = dac_code_q;
        dac_update_d = 1'b0;
        overrun_d    = overrun_q;

        if (overrun_clr) begin
            overrun_d = 1'b0;
        end

        if (!enable) begin
            // Open loop: park at mid-scale, announce it only if the code moves.
            state_d      = IDLE;
            acc_d        = '0;
            dac_code_d   = DAC_MID;
            dac_update_d = (dac_code_q != DAC_MID);
        end else begin
            if (err_valid && (state_q != IDLE)) begin
                overrun_d = 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (err_valid) begin
                        err_d   = err_data;
                        state_d = PROP;
                    end
                end
                PROP: begin
                    p_d     = err_q >>> KP_SHIFT;
                    acc_d   = ACC_WIDTH'(sat_add(
                                  {{(64 - ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q},
                                  {{(64 - DATA_WIDTH){err_q[DATA_WIDTH-1]}}, err_q},
                                  ACC_WIDTH));
                    state_d = INTEG;
                end
                INTEG: begin
                    i_d     = acc_q >>> KI_SHIFT;
                    state_d = SUM;
                end
                SUM: begin
                    sum_d   = clamped;
                    state_d = OUT;
                end
                OUT: begin
                    dac_code_d   = new_code;
                    dac_update_d = 1'b1;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            err_q        <= '0;
            p_q          <= '0;
            acc_q        <= '0;
            i_q          <= '0;
            sum_q        <= '0;
            dac_code_q   <= DAC_MID;
            dac_update_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            p_q          <= p_d;
            acc_q        <= acc_d;
            i_q          <= i_d;
            sum_q        <= sum_d;
            dac_code_q   <= dac_code_d;
            dac_update_q <= dac_update_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dac_code   = dac_code_q;
    assign dac_update = dac_update_q;
    assign busy       = (state_q != IDLE);
    assign overrun    = overrun_q;

endmodule
